// File: rtl/ovo_vote_sequencer_if.sv
// rtl/ovo_vote_sequencer_if.sv - handshake bundle between OvO sequencer and its upstream/binarySVM side
interface ovo_vote_sequencer_if #(
    parameter int N_CLASSES = 10
);
    localparam int N_PAIRS = N_CLASSES * (N_CLASSES - 1) / 2;
    localparam int CLASS_W = $clog2(N_CLASSES);
    localparam int PAIR_W  = $clog2(N_PAIRS);

    logic               start;
    logic               svm_ready;
    logic               svm_class;
    logic               svm_rst_n;
    logic [PAIR_W-1:0]  pair_idx;
    logic [CLASS_W-1:0] cls_a;
    logic [CLASS_W-1:0] cls_b;
    logic               busy;
    logic               valid;
    logic [CLASS_W-1:0] class_out;

    // Upstream / binarySVM side
    modport master (
        output start, svm_ready, svm_class,
        input  svm_rst_n, pair_idx, cls_a, cls_b, busy, valid, class_out
    );

    // Sequencer side
    modport slave (
        input  start, svm_ready, svm_class,
        output svm_rst_n, pair_idx, cls_a, cls_b, busy, valid, class_out
    );
endinterface

// File: rtl/ovo_vote_sequencer.sv
// rtl/ovo_vote_sequencer.sv - one-vs-one pair sequencer, vote tally and argmax
module ovo_vote_sequencer #(
    parameter int N_CLASSES = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    ovo_vote_sequencer_if.slave   bus
);
    localparam int N_PAIRS = N_CLASSES * (N_CLASSES - 1) / 2;
    localparam int CLASS_W = $clog2(N_CLASSES);
    localparam int PAIR_W  = $clog2(N_PAIRS);
    localparam int VOTE_W  = $clog2(N_CLASSES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_n;

    logic [VOTE_W-1:0]  votes [N_CLASSES];
    logic [CLASS_W-1:0] scan_idx;
    logic [CLASS_W-1:0] best;
    logic [VOTE_W-1:0]  best_votes;

    logic               last_pair;
    logic               last_scan;
    logic               cand_better;
    logic [CLASS_W-1:0] best_n;
    logic [CLASS_W-1:0] vote_idx;

    assign last_pair   = (bus.pair_idx == PAIR_W'(N_PAIRS - 1));
    assign last_scan   = (scan_idx == CLASS_W'(N_CLASSES - 1));
    // Strict compare keeps the earliest class on ties
    assign cand_better = (votes[scan_idx] > best_votes);
    assign best_n      = cand_better ? scan_idx : best;
    assign vote_idx    = bus.svm_class ? bus.cls_b : bus.cls_a;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (bus.start) state_n = S_RUN;
            S_RUN:    if (bus.svm_ready && last_pair) state_n = S_ARGMAX;
            S_ARGMAX: if (last_scan) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Pair walk, vote tally, argmax scan and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.svm_rst_n <= 1'b0;
            bus.pair_idx  <= '0;
            bus.cls_a     <= '0;
            bus.cls_b     <= '0;
            bus.busy      <= 1'b0;
            bus.valid     <= 1'b0;
            bus.class_out <= '0;
            scan_idx      <= '0;
            best          <= '0;
            best_votes    <= '0;
            for (int i = 0; i < N_CLASSES; i++) begin
                votes[i] <= '0;
            end
        end else begin
            bus.valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < N_CLASSES; i++) begin
                            votes[i] <= '0;
                        end
                        bus.pair_idx  <= '0;
                        bus.cls_a     <= '0;
                        bus.cls_b     <= CLASS_W'(1);
                        bus.svm_rst_n <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.svm_ready) begin
                        votes[vote_idx] <= votes[vote_idx] + VOTE_W'(1);
                        if (!last_pair) begin
                            // Advance in the same edge so the next SVM frame reads the new ROM entry
                            bus.pair_idx <= bus.pair_idx + PAIR_W'(1);
                            if (bus.cls_b == CLASS_W'(N_CLASSES - 1)) begin
                                bus.cls_a <= bus.cls_a + CLASS_W'(1);
                                bus.cls_b <= bus.cls_a + CLASS_W'(2);
                            end else begin
                                bus.cls_b <= bus.cls_b + CLASS_W'(1);
                            end
                        end else begin
                            bus.svm_rst_n <= 1'b0;
                            scan_idx      <= '0;
                            best          <= '0;
                            best_votes    <= '0;
                        end
                    end
                end
                S_ARGMAX: begin
                    if (cand_better) begin
                        best       <= scan_idx;
                        best_votes <= votes[scan_idx];
                    end
                    scan_idx <= scan_idx + CLASS_W'(1);
                    if (last_scan) begin
                        // Result and valid land together in the DONE cycle
                        bus.class_out <= best_n;
                        bus.valid     <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ovo_vote_sequencer.sv
// tb/tb_ovo_vote_sequencer.sv - self-checking bench for ovo_vote_sequencer
module tb_ovo_vote_sequencer;
    localparam int N  = 10;
    localparam int NP = N * (N - 1) / 2;
    localparam int F  = 3;
    localparam int LAT = 1 + NP * (F + 1) + N + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ovo_vote_sequencer_if #(.N_CLASSES(N)) bus ();

    ovo_vote_sequencer #(.N_CLASSES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int pa [NP];
    int pb [NP];
    int svm_cls [NP];
    int ref_votes [N];

    typedef struct {
        int mode;
        int exp_class;
        bit poke_run;
        bit poke_done;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int tie_winner(input int a, input int b);
        if (a == 3 && b == 5) return 3;
        if (a == 0 && b == 1) return 1;
        if (a == 0 && b == 3) return 0;
        if (b == 5 || a == 5) return 5;
        if (b == 3 || a == 3) return 3;
        return a;
    endfunction

    // Picks svm_class per pair and returns the expected class from vote counting
    function automatic int prepare(input int mode);
        int best;
        int bv;
        for (int c = 0; c < N; c++) ref_votes[c] = 0;
        for (int p = 0; p < NP; p++) begin
            case (mode)
                0: svm_cls[p] = 0;
                1: svm_cls[p] = 1;
                2: begin
                    if (pa[p] == 7)      svm_cls[p] = 0;
                    else if (pb[p] == 7) svm_cls[p] = 1;
                    else                 svm_cls[p] = int'($urandom_range(0, 1));
                end
                3: svm_cls[p] = (tie_winner(pa[p], pb[p]) == pb[p]) ? 1 : 0;
                default: svm_cls[p] = int'($urandom_range(0, 1));
            endcase
            ref_votes[svm_cls[p] != 0 ? pb[p] : pa[p]]++;
        end
        best = 0;
        bv = -1;
        for (int c = 0; c < N; c++) begin
            if (ref_votes[c] > bv) begin
                bv = ref_votes[c];
                best = c;
            end
        end
        return best;
    endfunction

    task automatic run_sample(input int mode, input int exp_tbl, input bit poke_run,
                              input bit poke_done, input int abort_at);
        int exp_cls;
        int t0;
        int seen;
        int wait_n;
        exp_cls = prepare(mode);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t0 = cyc_cnt;
        bus.start = 1'b0;
        chk("busy_after_start", int'(bus.busy), 1);
        chk("svm_rst_n_run", int'(bus.svm_rst_n), 1);
        for (int p = 0; p < NP; p++) begin
            if (p == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_svm_rst_n", int'(bus.svm_rst_n), 0);
                chk("abort_busy", int'(bus.busy), 0);
                chk("abort_pair_idx", int'(bus.pair_idx), 0);
                chk("abort_valid", int'(bus.valid), 0);
                @(negedge clk);
                rst = 1'b0;
                seen = 0;
                repeat (60) begin
                    @(negedge clk);
                    if (bus.valid) seen++;
                end
                chk("abort_no_valid", seen, 0);
                return;
            end
            wait_n = (p == 0) ? F + 1 : F;
            repeat (wait_n) @(posedge clk);
            @(negedge clk);
            bus.svm_ready = 1'b1;
            bus.svm_class = svm_cls[p][0];
            if (poke_run && p == 10) bus.start = 1'b1;
            chk($sformatf("pair_idx_%0d", p), int'(bus.pair_idx), p);
            chk($sformatf("cls_a_%0d", p), int'(bus.cls_a), pa[p]);
            chk($sformatf("cls_b_%0d", p), int'(bus.cls_b), pb[p]);
            @(posedge clk);
            @(negedge clk);
            bus.svm_ready = 1'b0;
            bus.start = 1'b0;
        end
        seen = 0;
        for (int k = 0; k < 3 * N && seen == 0; k++) begin
            if (bus.valid) begin
                seen = 1;
                chk("latency", cyc_cnt - t0 + 1, LAT);
                chk("class_model", int'(bus.class_out), exp_cls);
                if (exp_tbl >= 0) chk("class_table", int'(bus.class_out), exp_tbl);
                chk("busy_at_valid", int'(bus.busy), 0);
                if (poke_done) bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                chk("valid_pulse", int'(bus.valid), 0);
                chk("class_held", int'(bus.class_out), exp_cls);
                repeat (4) begin
                    @(negedge clk);
                    chk("idle_busy", int'(bus.busy), 0);
                    chk("idle_svm_rst_n", int'(bus.svm_rst_n), 0);
                end
            end else begin
                chk("busy_argmax", int'(bus.busy), 1);
                @(negedge clk);
            end
        end
        if (seen == 0) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int k;
        k = 0;
        for (int a = 0; a < N; a++) begin
            for (int b = a + 1; b < N; b++) begin
                pa[k] = a;
                pb[k] = b;
                k++;
            end
        end
        tbl[0] = '{0, 0, 1'b0, 1'b0};
        tbl[1] = '{1, 9, 1'b0, 1'b0};
        tbl[2] = '{2, 7, 1'b1, 1'b0};
        tbl[3] = '{3, 3, 1'b0, 1'b1};
        tbl[4] = '{4, -1, 1'b0, 1'b0};
        tbl[5] = '{4, -1, 1'b1, 1'b1};
        tbl[6] = '{4, -1, 1'b0, 1'b0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.svm_ready = 1'b0;
        bus.svm_class = 1'b0;
        #1;
        chk("rst_svm_rst_n", int'(bus.svm_rst_n), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_pair_idx", int'(bus.pair_idx), 0);
        chk("rst_class_out", int'(bus.class_out), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // svm_ready while idle must not disturb anything
        repeat (3) begin
            @(negedge clk);
            bus.svm_ready = 1'b1;
            bus.svm_class = 1'b1;
            @(negedge clk);
            bus.svm_ready = 1'b0;
            chk("idle_ready_busy", int'(bus.busy), 0);
            chk("idle_ready_valid", int'(bus.valid), 0);
            chk("idle_ready_pair", int'(bus.pair_idx), 0);
        end

        for (int i = 0; i < 7; i++) begin
            run_sample(tbl[i].mode, tbl[i].exp_class, tbl[i].poke_run, tbl[i].poke_done, -1);
        end

        // Reset mid-sample at pair 20, then a clean sample must still be right
        run_sample(4, -1, 1'b0, 1'b0, 20);
        run_sample(0, 0, 1'b0, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            run_sample(4, -1, 1'b0, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
